mem_access_stage: RTL and testbench

- Memory stage of the pipelined CPU. It sits between execute and the writeBack mux and produces the ldValue, aluOut and select values that writeBack consumes.
- Runs load/store transactions against the data memory over a req/ack handshake.
- Handles byte, half and word accesses with byte enables and sign/zero extension.
- Passes non-memory results through, and reports misalignment and timeout.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/load_align.sv | 25 ++
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, access-size encodings and the
// memory-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0, truncates
// to the access size and sign- or zero-extends to XLEN.
import cpu_pkg::*;

module load_align (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    value   = shifted;
    case (size)
      SZ_BYTE: value = {{(XLEN-8){sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: value = {{(XLEN-16){sign_ext & shifted[15]}}, shifted[15:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: runs load/store transactions over a req/ack
// handshake, passes ALU results through and flags misalignment/timeout.
import cpu_pkg::*;

module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              isLoad,
  input  logic              isStore,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   storeData,
  input  logic [XLEN-1:0]   aluIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   ldValue,
  output logic [XLEN-1:0]   aluOut,
  output logic              select,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  // Last wait-count value before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              store_q, store_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   alu_lat_q, alu_lat_d;
  logic [XLEN-1:0]   ldval_q, ldval_d;
  logic [XLEN-1:0]   aluout_q, aluout_d;
  logic              select_q, select_d;
  logic              err_q, err_d;
  logic [7:0]        wait_q, wait_d;

  logic              is_mem;
  logic              bad_access;
  logic [XLEN-1:0]   ld_aligned;

  load_align u_load_align (
    .rdata    (mem_rdata),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .value    (ld_aligned)
  );

  always_comb begin
    is_mem     = isLoad | isStore;
    bad_access = (size == 2'b11)
               || (size == SZ_HALF && addr[0])
               || (size == SZ_WORD && addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      store_q   <= 1'b0;
      sdata_q   <= '0;
      alu_lat_q <= '0;
      ldval_q   <= '0;
      aluout_q  <= '0;
      select_q  <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      store_q   <= store_d;
      sdata_q   <= sdata_d;
      alu_lat_q <= alu_lat_d;
      ldval_q   <= ldval_d;
      aluout_q  <= aluout_d;
      select_q  <= select_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sext_d    = sext_q;
    store_d   = store_q;
    sdata_d   = sdata_q;
    alu_lat_d = alu_lat_q;
    ldval_d   = ldval_q;
    aluout_d  = aluout_q;
    select_d  = select_q;
    err_d     = 1'b0;
    wait_d    = wait_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = addr;
          size_d    = size;
          sext_d    = signExt;
          store_d   = isStore & ~isLoad;
          sdata_d   = storeData;
          alu_lat_d = aluIn;
          if (!is_mem) begin
            state_d  = RESP;
            aluout_d = aluIn;
            select_d = 1'b0;
          end else if (bad_access) begin
            err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            wait_d  = '0;
          end
        end
      end
      ACCESS: begin
        // Ack is checked before the timeout so a same-edge ack wins.
        if (mem_ack) begin
          state_d  = RESP;
          aluout_d = alu_lat_q;
          select_d = ~store_q;
          if (!store_q) ldval_d = ld_aligned;
        end else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == ACCESS);
    mem_we    = mem_req & store_q;
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      case (size_q)
        SZ_BYTE: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{sdata_q[7:0]}};
        end
        SZ_HALF: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = sdata_q;
        end
      endcase
    end
    valid   = (state_q == RESP);
    busy    = (state_q != IDLE);
    err     = err_q;
    ldValue = ldval_q;
    aluOut  = aluout_q;
    select  = select_q;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        start, isLoad, isStore, signExt;
  logic [1:0]  size;
  logic [31:0] addr, storeData, aluIn;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] ldValue, aluOut;
  logic        select, valid, busy, err;

  int unsigned n_assert;
  int unsigned n_fail;

  mem_access_stage #(
    .TIMEOUT (16),
    .ADDR_W  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .isLoad    (isLoad),
    .isStore   (isStore),
    .size      (size),
    .signExt   (signExt),
    .addr      (addr),
    .storeData (storeData),
    .aluIn     (aluIn),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ldValue   (ldValue),
    .aluOut    (aluOut),
    .select    (select),
    .valid     (valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] alu);
    isLoad    = ld;
    isStore   = st;
    size      = sz;
    signExt   = sx;
    addr      = a;
    storeData = sd;
    aluIn     = alu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] byte_rdata;
    logic [31:0] byte_exp [2];
    logic        req_held;

    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_valid",   32'(valid),   32'd0);
    check_eq("rst_busy",    32'(busy),    32'd0);
    check_eq("rst_err",     32'(err),     32'd0);
    check_eq("rst_ldValue", ldValue,      32'h0);
    check_eq("rst_aluOut",  aluOut,       32'h0);
    check_eq("rst_be",      32'(mem_be),  32'h0);
    rst_n = 1'b1;
    tick();

    // Word load, ack in first ACCESS cycle
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0000_00AA);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wl_req",   32'(mem_req), 32'd1);
    check_eq("wl_we",    32'(mem_we),  32'd0);
    check_eq("wl_be",    32'(mem_be),  32'hF);
    check_eq("wl_addr",  mem_addr,     32'h100);
    check_eq("wl_valid_t1", 32'(valid), 32'd0);
    check_eq("wl_busy",  32'(busy),    32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    check_eq("wl_valid", 32'(valid),  32'd1);
    check_eq("wl_select", 32'(select), 32'd1);
    check_eq("wl_ld",    ldValue,     32'h1234_5678);
    check_eq("wl_req_drop", 32'(mem_req), 32'd0);
    tick();
    check_eq("wl_valid_once", 32'(valid), 32'd0);
    check_eq("wl_idle",  32'(busy),  32'd0);
    check_eq("wl_ld_hold", ldValue, 32'h1234_5678);

    // Byte loads at lane 3, signed then unsigned
    byte_rdata  = 32'h80FF_0000;
    byte_exp[0] = 32'h0000_0080;
    byte_exp[1] = 32'hFFFF_FF80;
    for (int unsigned i = 0; i < 2; i++) begin
      set_op(1'b1, 1'b0, 2'b00, 1'(1 - i), 32'h103, 32'h0, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("bl_be",   32'(mem_be), 32'h8);
      check_eq("bl_addr", mem_addr,    32'h100);
      mem_ack = 1'b1;
      mem_rdata = byte_rdata;
      tick();
      mem_ack = 1'b0;
      check_eq("bl_valid", 32'(valid), 32'd1);
      check_eq("bl_ld",    ldValue,    byte_exp[1 - i]);
      tick();
    end

    // Half store at lane 2
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h1111_2222);
    start = 1'b1;
    tick();
    start = 1'b0;
    storeData = 32'h0;
    check_eq("hs_we",    32'(mem_we), 32'd1);
    check_eq("hs_be",    32'(mem_be), 32'hC);
    check_eq("hs_wdata", mem_wdata,   32'hBEEF_BEEF);
    check_eq("hs_addr",  mem_addr,    32'h200);
    tick();
    check_eq("hs_stable_wdata", mem_wdata, 32'hBEEF_BEEF);
    check_eq("hs_stable_req",   32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("hs_valid",  32'(valid),  32'd1);
    check_eq("hs_select", 32'(select), 32'd0);
    check_eq("hs_aluOut", aluOut,      32'h1111_2222);
    check_eq("hs_ld_hold", ldValue,    32'h0000_0080);
    tick();
    check_eq("hs_idle_wdata", mem_wdata, 32'h0);

    // Pass-through with a start held during RESP (must be ignored)
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h8765_4321);
    start = 1'b1;
    tick();
    check_eq("pt_valid",  32'(valid),  32'd1);
    check_eq("pt_select", 32'(select), 32'd0);
    check_eq("pt_aluOut", aluOut,      32'h8765_4321);
    check_eq("pt_busy",   32'(busy),   32'd1);
    aluIn = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check_eq("pt_no_extra_valid", 32'(valid), 32'd0);
    check_eq("pt_aluOut_hold",    aluOut,     32'h8765_4321);
    tick();
    check_eq("pt_still_idle", 32'(valid | busy), 32'd0);

    // Misaligned word load
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("mis_err",  32'(err),     32'd1);
    check_eq("mis_req",  32'(mem_req), 32'd0);
    check_eq("mis_busy", 32'(busy),    32'd0);
    tick();
    check_eq("mis_err_pulse", 32'(err), 32'd0);

    // Timeout: ack withheld for all 16 ACCESS cycles
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    req_held = 1'b1;
    for (int unsigned c = 0; c < 15; c++) begin
      req_held = req_held & mem_req & ~err & ~valid;
      tick();
    end
    req_held = req_held & mem_req & ~err;
    check_eq("to_req_held", 32'(req_held), 32'd1);
    tick();
    check_eq("to_err",   32'(err),     32'd1);
    check_eq("to_req",   32'(mem_req), 32'd0);
    check_eq("to_valid", 32'(valid),   32'd0);
    tick();
    check_eq("to_err_pulse", 32'(err | valid), 32'd0);

    // Ack on the timeout edge wins
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    check_eq("aw_valid", 32'(valid), 32'd1);
    check_eq("aw_err",   32'(err),   32'd0);
    check_eq("aw_ld",    ldValue,    32'hCAFE_F00D);
    tick();

    // Asynchronous reset during ACCESS, then a late ack
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ra_req_before", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ra_req",   32'(mem_req), 32'd0);
    check_eq("ra_busy",  32'(busy),    32'd0);
    check_eq("ra_valid", 32'(valid),   32'd0);
    check_eq("ra_ld",    ldValue,      32'h0);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    check_eq("ra_late_ack_valid", 32'(valid), 32'd0);
    check_eq("ra_late_ack_busy",  32'(busy),  32'd0);
    tick();
    check_eq("ra_late_ack_valid2", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
